// File: rtl/md_ctrl_pkg.sv
// md_ctrl_pkg: shared encodings for the multiply/divide sequencing controller.
//   - md_sel_e   : E-stage MD operation codes (4 bits)
//   - md_state_e : controller states
//   - is_md_start / is_md_div : op classification helpers
package md_ctrl_pkg;

   localparam int unsigned CntW = 4;

   typedef enum logic [3:0] {
      MD_NONE = 4'd0,
      MULT    = 4'd1,
      MULTU   = 4'd2,
      DIV     = 4'd3,
      DIVU    = 4'd4,
      MFHI    = 4'd5,
      MFLO    = 4'd6,
      MTHI    = 4'd7,
      MTLO    = 4'd8
   } md_sel_e;

   typedef enum logic [0:0] {
      StIdle = 1'b0,
      StRun  = 1'b1
   } md_state_e;

   // True for the four ops that occupy the MDU; codes 9..15 fall through as MD_NONE.
   function automatic logic is_md_start(logic [3:0] op);
      return (op == MULT) || (op == MULTU) || (op == DIV) || (op == DIVU);
   endfunction

   function automatic logic is_md_div(logic [3:0] op);
      return (op == DIV) || (op == DIVU);
   endfunction

endpackage

// File: rtl/md_ctrl_if.sv
// md_ctrl_if: pipeline <-> MD controller signal bundle.
//   master : pipeline side (drives E/D-stage info, receives control)
//   slave  : md_ctrl side
//   e_valid, e_flush, e_md_sel[3:0], d_md_use          pipeline -> controller
//   md_start, md_op[3:0], md_busy, hilo_commit,
//   d_stall, perf_stall_cnt[15:0]                       controller -> pipeline
interface md_ctrl_if;

   logic        e_valid;
   logic        e_flush;
   logic [3:0]  e_md_sel;
   logic        d_md_use;
   logic        md_start;
   logic [3:0]  md_op;
   logic        md_busy;
   logic        hilo_commit;
   logic        d_stall;
   logic [15:0] perf_stall_cnt;

   modport master (
      output e_valid, e_flush, e_md_sel, d_md_use,
      input  md_start, md_op, md_busy, hilo_commit, d_stall, perf_stall_cnt
   );

   modport slave (
      input  e_valid, e_flush, e_md_sel, d_md_use,
      output md_start, md_op, md_busy, hilo_commit, d_stall, perf_stall_cnt
   );

endinterface

// File: rtl/md_ctrl.sv
// md_ctrl: issue/latency sequencer for the E-stage multiply/divide unit.
//   clk   : system clock, rising edge
//   reset : asynchronous, active-high
//   bus   : md_ctrl_if.slave (E/D-stage inputs, start/op/busy/commit/stall/perf outputs)
// Parameters MULT_CYCLES / DIV_CYCLES (1..15): busy cycles after issue.
// Optional macro MD_PERF_EN builds a saturating stall-cycle counter on
// perf_stall_cnt; without it the output is tied to zero.
module md_ctrl
   import md_ctrl_pkg::*;
#(
   parameter int unsigned MULT_CYCLES = 5,
   parameter int unsigned DIV_CYCLES  = 10
) (
   input logic        clk,
   input logic        reset,
   md_ctrl_if.slave   bus
);

   if (MULT_CYCLES < 1 || MULT_CYCLES > 15) begin : g_bad_mult_cycles
      $error("md_ctrl: MULT_CYCLES must be in 1..15");
   end
   if (DIV_CYCLES < 1 || DIV_CYCLES > 15) begin : g_bad_div_cycles
      $error("md_ctrl: DIV_CYCLES must be in 1..15");
   end

   localparam logic [CntW-1:0] MultCnt = CntW'(MULT_CYCLES);
   localparam logic [CntW-1:0] DivCnt  = CntW'(DIV_CYCLES);

   md_state_e       state_q, state_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic [3:0]      md_op_q, md_op_d;
   logic            issue_ok;
   logic            busy;

   assign busy = (state_q == StRun);

   // Reset gating keeps md_start/d_stall low while reset is held.
   assign issue_ok = ~reset & bus.e_valid & ~bus.e_flush & is_md_start(bus.e_md_sel) &
                     (state_q == StIdle);

   always_comb begin
      state_d         = state_q;
      cnt_d           = cnt_q;
      md_op_d         = md_op_q;
      bus.hilo_commit = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (issue_ok) begin
               state_d = StRun;
               md_op_d = bus.e_md_sel;
               cnt_d   = is_md_div(bus.e_md_sel) ? DivCnt : MultCnt;
            end
         end
         StRun: begin
            // E-stage inputs are ignored here: an issued op always completes.
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == CntW'(1)) begin
               bus.hilo_commit = 1'b1;
               state_d         = StIdle;
               md_op_d         = MD_NONE;
            end
         end
         default: begin
            state_d = StIdle;
            md_op_d = MD_NONE;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         md_op_q <= MD_NONE;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         md_op_q <= md_op_d;
      end
   end

   assign bus.md_start = issue_ok;
   assign bus.md_op    = md_op_q;
   assign bus.md_busy  = busy;
   assign bus.d_stall  = ~reset & bus.d_md_use & (busy | issue_ok);

`ifdef MD_PERF_EN
   logic [15:0] perf_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         perf_q <= '0;
      end else if (bus.d_stall && (perf_q != 16'hFFFF)) begin
         perf_q <= perf_q + 16'd1;
      end
   end

   assign bus.perf_stall_cnt = perf_q;
`else
   assign bus.perf_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_md_ctrl.sv
// tb_md_ctrl: randomized + directed bench for md_ctrl with a timeline-based
// reference model (issue cycle / end cycle) checked on every falling edge.
module tb_md_ctrl;
   import md_ctrl_pkg::*;

   localparam int MULT_N = 5;
   localparam int DIV_N  = 10;

   logic clk;
   logic reset;
   md_ctrl_if bus ();

   md_ctrl #(
      .MULT_CYCLES (MULT_N),
      .DIV_CYCLES  (DIV_N)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference model: an issued op owns the unit for cycles (iss, end_c].
   bit          m_active = 0;
   int          m_iss    = 0;
   int          m_end    = 0;
   logic [3:0]  m_op     = 4'd0;
   logic [15:0] m_perf   = 16'd0;

   function automatic bit start_class(logic [3:0] s);
      return s inside {4'd1, 4'd2, 4'd3, 4'd4};
   endfunction

   always @(negedge clk) begin
      if (reset) begin
         check("rst_start", {31'd0, bus.md_start}, 32'd0);
         check("rst_busy", {31'd0, bus.md_busy}, 32'd0);
         check("rst_commit", {31'd0, bus.hilo_commit}, 32'd0);
         check("rst_stall", {31'd0, bus.d_stall}, 32'd0);
         check("rst_op", {28'd0, bus.md_op}, 32'd0);
         check("rst_perf", {16'd0, bus.perf_stall_cnt}, 32'd0);
         m_active <= 0;
         m_perf   <= 16'd0;
      end else begin
         bit busy_e, commit_e, start_e, stall_e;
         logic [3:0] op_e;
         busy_e   = m_active && (cyc > m_iss) && (cyc <= m_end);
         commit_e = busy_e && (cyc == m_end);
         op_e     = busy_e ? m_op : 4'd0;
         start_e  = bus.e_valid && !bus.e_flush && start_class(bus.e_md_sel) && !busy_e;
         stall_e  = bus.d_md_use && (busy_e || start_e);
         check("start", {31'd0, bus.md_start}, {31'd0, start_e});
         check("busy", {31'd0, bus.md_busy}, {31'd0, busy_e});
         check("commit", {31'd0, bus.hilo_commit}, {31'd0, commit_e});
         check("stall", {31'd0, bus.d_stall}, {31'd0, stall_e});
         check("op", {28'd0, bus.md_op}, {28'd0, op_e});
         check("perf", {16'd0, bus.perf_stall_cnt}, {16'd0, m_perf});
         if (start_e) begin
            m_active <= 1;
            m_iss    <= cyc;
            m_end    <= cyc + ((bus.e_md_sel inside {4'd3, 4'd4}) ? DIV_N : MULT_N);
            m_op     <= bus.e_md_sel;
         end
`ifdef MD_PERF_EN
         if (stall_e && m_perf != 16'hFFFF) m_perf <= m_perf + 16'd1;
`endif
      end
   end

   task automatic drive(input logic v, input logic f, input logic [3:0] sel, input logic use_d);
      @(posedge clk);
      #1;
      bus.e_valid  = v;
      bus.e_flush  = f;
      bus.e_md_sel = sel;
      bus.d_md_use = use_d;
   endtask

   task automatic sample();
      @(negedge clk);
      #1;
   endtask

   initial begin
      int commits;
      reset        = 1'b1;
      bus.e_valid  = 1'b0;
      bus.e_flush  = 1'b0;
      bus.e_md_sel = 4'd0;
      bus.d_md_use = 1'b0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      repeat (2) drive(0, 0, 4'd0, 0);

      // mult: start at T, busy T+1..T+5, commit only at T+5
      drive(1, 0, 4'd1, 0);
      sample();
      check("mult_start", {31'd0, bus.md_start}, 32'd1);
      for (int k = 1; k <= 6; k++) begin
         drive(0, 0, 4'd0, 0);
         sample();
         check("mult_busy", {31'd0, bus.md_busy}, (k <= 5) ? 32'd1 : 32'd0);
         check("mult_commit", {31'd0, bus.hilo_commit}, (k == 5) ? 32'd1 : 32'd0);
      end

      // divu with mfhi waiting in D: stall T..T+10
      drive(1, 0, 4'd4, 1);
      sample();
      check("divu_stall0", {31'd0, bus.d_stall}, 32'd1);
      for (int k = 1; k <= 11; k++) begin
         drive(0, 0, 4'd0, 1);
         sample();
         check("divu_stall", {31'd0, bus.d_stall}, (k <= 10) ? 32'd1 : 32'd0);
      end

      // flush in issue cycle
      drive(1, 1, 4'd3, 0);
      sample();
      check("flush_start", {31'd0, bus.md_start}, 32'd0);
      commits = 0;
      for (int k = 1; k <= 12; k++) begin
         drive(0, 0, 4'd0, 0);
         sample();
         check("flush_busy", {31'd0, bus.md_busy}, 32'd0);
         if (bus.hilo_commit) commits++;
      end
      check("flush_commits", commits, 32'd0);

      // back-to-back mult then multu held in E
      drive(1, 0, 4'd1, 0);
      sample();
      check("b2b_start0", {31'd0, bus.md_start}, 32'd1);
      for (int k = 1; k <= 11; k++) begin
         drive((k <= 6) ? 1'b1 : 1'b0, 0, 4'd2, 0);
         sample();
         check("b2b_start", {31'd0, bus.md_start}, (k == 6) ? 32'd1 : 32'd0);
         check("b2b_commit", {31'd0, bus.hilo_commit}, (k == 5 || k == 11) ? 32'd1 : 32'd0);
         if (k == 7) check("b2b_op", {28'd0, bus.md_op}, 32'd2);
      end
      drive(0, 0, 4'd0, 0);

      // reset between edges in the middle of a div
      drive(1, 0, 4'd3, 0);
      sample();
      for (int k = 1; k <= 3; k++) begin
         drive(0, 0, 4'd0, 0);
         sample();
      end
      check("rmid_busy_before", {31'd0, bus.md_busy}, 32'd1);
      reset = 1'b1;
      #1;
      check("rmid_busy", {31'd0, bus.md_busy}, 32'd0);
      check("rmid_op", {28'd0, bus.md_op}, 32'd0);
      check("rmid_commit", {31'd0, bus.hilo_commit}, 32'd0);
      @(negedge clk);
      @(posedge clk);
      #1 reset = 1'b0;
      commits = 0;
      for (int k = 1; k <= 12; k++) begin
         drive(0, 0, 4'd0, 0);
         sample();
         if (bus.hilo_commit) commits++;
      end
      check("rmid_commits", commits, 32'd0);

      // randomized traffic, incl. mt*/mf*, illegal codes, flushes and rare resets
      for (int i = 0; i < 3000; i++) begin
         logic [3:0] sel;
         sel = ($urandom % 2 == 0) ? 4'($urandom_range(1, 4)) : 4'($urandom_range(0, 15));
         drive(($urandom % 4) != 0, ($urandom % 8) == 0, sel, ($urandom % 3) == 0);
         reset = (($urandom % 300) == 0);
      end
      drive(0, 0, 4'd0, 0);
      reset = 1'b0;
      repeat (20) drive(0, 0, 4'd0, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

endmodule
